// File: rtl/multicycle_sequencer.sv
// Multicycle fetch/decode/execute/memory/writeback controller with pm/dm wait-state handshakes.
// Optional hardware call/return stack is built when CTRL_CALL_STACK_EN is defined.
module multicycle_sequencer #(
  parameter int PC_WIDTH    = 6,
  parameter int DATA_WIDTH  = 16,
  parameter int RESET_PC    = 0,
  parameter int STACK_DEPTH = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  zero_flag,
  input  logic                  pos_flag,
  input  logic [15:0]           pm_data,
  input  logic                  pm_ready,
  input  logic                  dm_ready,
  output logic                  pm_req,
  output logic                  dm_req,
  output logic                  rf_write,
  output logic [2:0]            rs_addr,
  output logic [2:0]            rt_addr,
  output logic [2:0]            rd_addr,
  output logic [DATA_WIDTH-1:0] imm_data,
  output logic [3:0]            alu_sel,
  output logic                  imm_sel,
  output logic                  mem_write,
  output logic                  mem_sel,
  output logic [PC_WIDTH-1:0]   PC,
  output logic                  halted,
  output logic                  stack_err
);

  localparam logic [2:0] S_FETCH     = 3'd0;
  localparam logic [2:0] S_DECODE    = 3'd1;
  localparam logic [2:0] S_EXECUTE   = 3'd2;
  localparam logic [2:0] S_MEMORY    = 3'd3;
  localparam logic [2:0] S_WRITEBACK = 3'd4;
  localparam logic [2:0] S_HALT      = 3'd5;

  localparam logic [3:0] OP_LAST_ALU = 4'd8;
  localparam logic [3:0] OP_LD       = 4'd9;
  localparam logic [3:0] OP_ST       = 4'd10;
  localparam logic [3:0] OP_MOV      = 4'd11;
  localparam logic [3:0] OP_CMP      = 4'd12;
  localparam logic [3:0] OP_BEQ      = 4'd13;
  localparam logic [3:0] OP_BXT      = 4'd14;
  localparam logic [3:0] OP_SYS      = 4'd15;

  logic [2:0]          state;
  logic [15:0]         instr;
  logic [10:0]         off;
  logic [3:0]          opcode;
  logic [PC_WIDTH-1:0] branch_target;
  logic [PC_WIDTH-1:0] jump_target;
  logic [PC_WIDTH-1:0] call_target;
  logic                bxt_taken;

  assign opcode = instr[15:12];

  // PC already points past the branch, so the target is simply PC plus the sign-extended offset.
  assign branch_target = PC + PC_WIDTH'({{21{off[10]}}, off});
  assign jump_target   = PC_WIDTH'({21'd0, instr[10:0]});
  assign call_target   = PC_WIDTH'({22'd0, instr[9:0]});
  assign bxt_taken     = instr[11] ? (pos_flag & ~zero_flag) : (~pos_flag & ~zero_flag);

`ifdef CTRL_CALL_STACK_EN
  localparam int SPW = $clog2(STACK_DEPTH + 1);
  localparam int IW  = $clog2(STACK_DEPTH);

  logic [PC_WIDTH-1:0] stack [STACK_DEPTH];
  logic [SPW-1:0]      sp;
  logic [IW-1:0]       push_idx;
  logic [IW-1:0]       pop_idx;
  logic                err;

  assign push_idx  = IW'(sp);
  assign pop_idx   = push_idx - IW'(1);
  assign stack_err = err;
`else
  assign stack_err = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= S_FETCH;
      instr    <= '0;
      off      <= '0;
      PC       <= PC_WIDTH'(RESET_PC);
      rs_addr  <= '0;
      rt_addr  <= '0;
      rd_addr  <= '0;
      imm_data <= '0;
      alu_sel  <= '0;
      imm_sel  <= 1'b0;
      mem_sel  <= 1'b0;
`ifdef CTRL_CALL_STACK_EN
      sp       <= '0;
      err      <= 1'b0;
`endif
    end else begin
      case (state)
        S_FETCH: begin
          if (pm_ready) begin
            instr <= pm_data;
            PC    <= PC + PC_WIDTH'(1);
            state <= S_DECODE;
          end
        end

        S_DECODE: begin
          imm_sel <= ~instr[11];
          mem_sel <= 1'b0;
          if (opcode <= OP_LAST_ALU) begin
            rd_addr  <= instr[10:8];
            rs_addr  <= instr[7:5];
            rt_addr  <= instr[2:0];
            imm_data <= DATA_WIDTH'(instr[4:0]);
          end else if (opcode <= OP_CMP) begin
            rd_addr  <= instr[10:8];
            rs_addr  <= instr[10:8];
            rt_addr  <= instr[2:0];
            imm_data <= DATA_WIDTH'(instr[7:0]);
          end else begin
            off <= instr[10:0];
          end
          state <= S_EXECUTE;
        end

        S_EXECUTE: begin
          alu_sel <= opcode;
          state   <= S_FETCH;
          case (opcode)
            OP_LD: begin
              mem_sel <= 1'b1;
              state   <= S_MEMORY;
            end
            OP_ST:  state <= S_MEMORY;
            OP_MOV: state <= S_WRITEBACK;
            OP_CMP: state <= S_FETCH;
            OP_BEQ: begin
              if (zero_flag) PC <= branch_target;
            end
            OP_BXT: begin
              if (bxt_taken) PC <= branch_target;
            end
            OP_SYS: begin
              if (!instr[11]) begin
                PC <= jump_target;
              end else if (!instr[10]) begin
`ifdef CTRL_CALL_STACK_EN
                if (sp == SPW'(STACK_DEPTH)) begin
                  err   <= 1'b1;
                  state <= S_HALT;
                end else begin
                  stack[push_idx] <= PC;
                  sp              <= sp + SPW'(1);
                  PC              <= call_target;
                end
`else
                PC <= call_target;
`endif
              end else if (!instr[9]) begin
`ifdef CTRL_CALL_STACK_EN
                if (sp == '0) begin
                  err   <= 1'b1;
                  state <= S_HALT;
                end else begin
                  PC <= stack[pop_idx];
                  sp <= sp - SPW'(1);
                end
`endif
              end else begin
                state <= S_HALT;
              end
            end
            default: state <= S_WRITEBACK;
          endcase
        end

        S_MEMORY: begin
          if (dm_ready) state <= (opcode == OP_LD) ? S_WRITEBACK : S_FETCH;
        end

        S_WRITEBACK: state <= S_FETCH;
        S_HALT:      state <= S_HALT;
        default:     state <= S_FETCH;
      endcase
    end
  end

  // Strobes come straight from the registered state so they cannot glitch.
  assign pm_req    = (state == S_FETCH);
  assign dm_req    = (state == S_MEMORY);
  assign mem_write = (state == S_MEMORY) && (opcode == OP_ST);
  assign rf_write  = (state == S_WRITEBACK);
  assign halted    = (state == S_HALT);

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed self-checking bench for multicycle_sequencer; stack checks follow CTRL_CALL_STACK_EN.
module tb_multicycle_sequencer;
  logic        clock = 1'b0;
  logic        reset;
  logic        zero_flag, pos_flag;
  logic [15:0] pm_data;
  logic        pm_ready, dm_ready;
  logic        pm_req, dm_req, rf_write, imm_sel, mem_write, mem_sel, halted, stack_err;
  logic [2:0]  rs_addr, rt_addr, rd_addr;
  logic [15:0] imm_data;
  logic [3:0]  alu_sel;
  logic [5:0]  PC;

  int passed = 0;
  int failed = 0;
  int total  = 0;
  int cnt_pm, cnt_dm, cnt_rf, cnt_mw;

  multicycle_sequencer #(
    .PC_WIDTH(6), .DATA_WIDTH(16), .RESET_PC(0), .STACK_DEPTH(2)
  ) dut (
    .clock(clock), .reset(reset), .zero_flag(zero_flag), .pos_flag(pos_flag),
    .pm_data(pm_data), .pm_ready(pm_ready), .dm_ready(dm_ready),
    .pm_req(pm_req), .dm_req(dm_req), .rf_write(rf_write),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .rd_addr(rd_addr),
    .imm_data(imm_data), .alu_sel(alu_sel), .imm_sel(imm_sel),
    .mem_write(mem_write), .mem_sel(mem_sel), .PC(PC),
    .halted(halted), .stack_err(stack_err)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic sample();
    if (pm_req)    cnt_pm++;
    if (dm_req)    cnt_dm++;
    if (rf_write)  cnt_rf++;
    if (mem_write) cnt_mw++;
  endtask

  task automatic clear();
    cnt_pm = 0; cnt_dm = 0; cnt_rf = 0; cnt_mw = 0;
    sample();
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
    sample();
  endtask

  // Fetch with no stall, then step through DECODE and EXECUTE back to the next state.
  task automatic exec3(input logic [15:0] ins);
    pm_data = ins; pm_ready = 1'b1;
    cyc();
    pm_ready = 1'b0;
    cyc();
    cyc();
  endtask

  initial begin
    reset = 1'b1; zero_flag = 1'b0; pos_flag = 1'b0;
    pm_data = '0; pm_ready = 1'b0; dm_ready = 1'b0;
    @(posedge clock); @(posedge clock); #1;
    reset = 1'b0;
    chk("rst_pm_req", 32'(pm_req), 1);
    chk("rst_pc", 32'(PC), 0);
    chk("rst_strobes", {28'd0, rf_write, dm_req, mem_write, halted}, 0);
    chk("rst_regs", {imm_data, alu_sel, 3'd0, mem_sel, 3'd0, imm_sel, 3'd0, stack_err}, 0);

    // ADD rd=2 rs=2 rt=5
    pm_data = 16'h0245; pm_ready = 1'b1;
    clear();
    cyc(); pm_ready = 1'b0;
    chk("add_c2_pm_req", 32'(pm_req), 0);
    chk("add_pc", 32'(PC), 1);
    cyc();
    chk("add_addrs", {23'd0, rd_addr, rs_addr, rt_addr}, {23'd0, 3'd2, 3'd2, 3'd5});
    chk("add_c3_rf_write", 32'(rf_write), 0);
    cyc();
    chk("add_c4_rf_write", 32'(rf_write), 1);
    chk("add_alu_sel", 32'(alu_sel), 0);
    cyc();
    chk("add_c5_pm_req", 32'(pm_req), 1);
    chk("add_rf_count", 32'(cnt_rf), 1);

    // 3 fetch stall cycles then MOV r3, #0xA7
    clear(); cyc(); cyc(); cyc();
    pm_data = 16'hB3A7; pm_ready = 1'b1;
    cyc(); pm_ready = 1'b0;
    cyc();
    chk("mov_imm", 32'(imm_data), 32'h00A7);
    chk("mov_imm_sel", 32'(imm_sel), 1);
    chk("mov_rd", 32'(rd_addr), 3);
    cyc();
    chk("mov_pm_req_count", 32'(cnt_pm), 4);
    chk("mov_alu_sel", 32'(alu_sel), 11);
    cyc();
    chk("mov_rf_count", 32'(cnt_rf), 1);
    chk("mov_pc", 32'(PC), 2);

    // LD with dm_ready two cycles late
    pm_data = 16'h9100; pm_ready = 1'b1;
    clear();
    cyc(); pm_ready = 1'b0;
    cyc();
    cyc();
    chk("ld_mem_sel_m1", 32'(mem_sel), 1);
    chk("ld_dm_req_m1", 32'(dm_req), 1);
    cyc(); cyc(); dm_ready = 1'b1;
    cyc(); dm_ready = 1'b0;
    chk("ld_mem_sel_wb", 32'(mem_sel), 1);
    chk("ld_rf_write_wb", 32'(rf_write), 1);
    cyc();
    chk("ld_dm_count", 32'(cnt_dm), 3);
    chk("ld_rf_count", 32'(cnt_rf), 1);
    chk("ld_mw_count", 32'(cnt_mw), 0);

    // ST with dm_ready two cycles late
    pm_data = 16'hA200; pm_ready = 1'b1;
    clear();
    cyc(); pm_ready = 1'b0;
    cyc(); cyc(); cyc(); cyc(); dm_ready = 1'b1;
    cyc(); dm_ready = 1'b0;
    chk("st_mw_count", 32'(cnt_mw), 3);
    chk("st_rf_count", 32'(cnt_rf), 0);
    chk("st_back_to_fetch", 32'(pm_req), 1);
    chk("st_pc", 32'(PC), 4);

    // CMP then branches
    exec3(16'hC000);
    chk("cmp_latency", 32'(pm_req), 1);
    chk("cmp_pc", 32'(PC), 5);
    zero_flag = 1'b1; exec3(16'hD7FE);
    chk("beq_taken_pc", 32'(PC), 4);
    zero_flag = 1'b0; exec3(16'hC000);
    exec3(16'hD7FE);
    chk("beq_not_taken_pc", 32'(PC), 6);
    pos_flag = 1'b1; zero_flag = 1'b0; exec3(16'hE803);
    chk("bgt_taken_pc", 32'(PC), 10);
    pos_flag = 1'b0; zero_flag = 1'b1; exec3(16'hE003);
    chk("blt_zero_not_taken_pc", 32'(PC), 11);
    zero_flag = 1'b0; exec3(16'hE002);
    chk("blt_taken_pc", 32'(PC), 14);
    exec3(16'hF003);
    chk("j_pc", 32'(PC), 3);

`ifdef CTRL_CALL_STACK_EN
    exec3(16'hF810);
    chk("call_pc", 32'(PC), 32'h10);
    exec3(16'hFC00);
    chk("ret_pc", 32'(PC), 4);
    chk("ret_stack_err", 32'(stack_err), 0);
    exec3(16'hF810);
    exec3(16'hF810);
    chk("call2_pc", 32'(PC), 32'h10);
    exec3(16'hF810);
    chk("overflow_stack_err", 32'(stack_err), 1);
    chk("overflow_halted", 32'(halted), 1);
    chk("overflow_pc", 32'(PC), 32'h11);
    reset = 1'b1; cyc(); reset = 1'b0;
    chk("err_cleared_by_reset", 32'(stack_err), 0);
    chk("err_reset_pc", 32'(PC), 0);
`else
    exec3(16'hF810);
    chk("call_as_j_pc", 32'(PC), 32'h10);
    exec3(16'hFC00);
    chk("ret_nop_pc", 32'(PC), 32'h11);
    chk("ret_nop_fetch", 32'(pm_req), 1);
    chk("no_stack_err", 32'(stack_err), 0);
`endif

    // HALT is absorbing until reset
    exec3(16'hFE00);
    chk("halt_halted", 32'(halted), 1);
    pm_ready = 1'b1;
    clear();
    repeat (9) cyc();
    chk("halt_pm_req_count", 32'(cnt_pm), 0);
    chk("halt_still_halted", 32'(halted), 1);
    pm_ready = 1'b0;
    reset = 1'b1; cyc(); reset = 1'b0;
    chk("halt_reset_pc", 32'(PC), 0);
    chk("halt_reset_fetch", 32'(pm_req), 1);
    chk("halt_reset_halted", 32'(halted), 0);

    // Reset in the middle of a stalled ST
    pm_data = 16'hA200; pm_ready = 1'b1;
    cyc(); pm_ready = 1'b0;
    cyc(); cyc();
    chk("st_stall_mem_write", 32'(mem_write), 1);
    reset = 1'b1; cyc(); reset = 1'b0;
    chk("st_abort_mem_write", 32'(mem_write), 0);
    chk("st_abort_dm_req", 32'(dm_req), 0);
    chk("st_abort_pc", 32'(PC), 0);
    clear();
    repeat (3) cyc();
    chk("st_abort_mw_count", 32'(cnt_mw), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
